// File: rtl/clockgen_seq.sv
// clockgen_seq: reset/lock sequencer for the board clock generator.
// Holds the generator in reset, waits for a stable lock, retries on lock
// timeout, and releases the downstream system reset only while locked.
module clockgen_seq #(
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16
) (
    input  logic       CLK_IN,
    input  logic       RSTN_IN,
    input  logic       LOCKED_IN,
    input  logic       RESTART_IN,
    output logic       DCM_RST_OUT,
    output logic       SYS_RSTN_OUT,
    output logic       READY_OUT,
    output logic       FAIL_OUT,
    output logic [3:0] RETRY_CNT_OUT,
    output logic [1:0] STATE_OUT
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAIL      = 2'd3
    } state_t;

    // Terminal counts are compared against the pre-increment counter value,
    // so each state leaves on the edge where its counter holds limit-1.
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [3:0]       RETRY_ONE = 4'd1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [3:0]       retry_q, retry_d;
    logic             dcm_rst_q, dcm_rst_d;
    logic             sys_rstn_q, sys_rstn_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    // Next-state, counter and output decode; RESTART_IN overrides all state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stab_d  = stab_q;
        retry_d = retry_q;

        if (RESTART_IN) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            stab_d  = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                        // Any lock glitch seen while the generator was held
                        // in reset must not count toward stability.
                        stab_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    cnt_d  = cnt_q + CNT_ONE;
                    stab_d = LOCKED_IN ? (stab_q + CNT_ONE) : '0;
                    // Lock is checked first so it wins over a coincident timeout.
                    if (LOCKED_IN && (stab_q == STAB_LAST)) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RETRY_ONE;
                            state_d = ST_RESET;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
                ST_RUN: begin
                    // Lock loss restarts the sequence with a fresh retry budget
                    // (retry is already zero here).
                    if (!LOCKED_IN) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                    end
                end
                ST_FAIL: begin
                    // Terminal: only RESTART_IN or RSTN_IN leave this state.
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        dcm_rst_d  = (state_d == ST_RESET) || (state_d == ST_FAIL);
        sys_rstn_d = (state_d == ST_RUN);
        ready_d    = (state_d == ST_RUN);
        fail_d     = (state_d == ST_FAIL);
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLK_IN) begin
        if (!RSTN_IN) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            stab_q     <= '0;
            retry_q    <= '0;
            dcm_rst_q  <= 1'b1;
            sys_rstn_q <= 1'b0;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stab_q     <= stab_d;
            retry_q    <= retry_d;
            dcm_rst_q  <= dcm_rst_d;
            sys_rstn_q <= sys_rstn_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign DCM_RST_OUT   = dcm_rst_q;
    assign SYS_RSTN_OUT  = sys_rstn_q;
    assign READY_OUT     = ready_q;
    assign FAIL_OUT      = fail_q;
    assign RETRY_CNT_OUT = retry_q;
    assign STATE_OUT     = state_q;

endmodule

// File: tb/tb_clockgen_seq.sv
// Testbench for clockgen_seq: table vectors, directed multi-cycle sequences
// and randomized stimulus against a behavioural reference model.
module tb_clockgen_seq;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 3;
    localparam int LOCK_TIMEOUT = 20;
    localparam int MAX_RETRY    = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       dcm_rst, sys_rstn, ready, fail;
    logic [3:0] retry_cnt;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: mode 0=RESET 1=WAIT_LOCK 2=RUN 3=FAIL
    int m_mode    = 0;
    int m_elapsed = 0;
    int m_run     = 0;
    int m_retries = 0;

    clockgen_seq #(
        .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY), .CNT_W(16)
    ) dut (
        .CLK_IN(clk), .RSTN_IN(rstn), .LOCKED_IN(locked), .RESTART_IN(restart),
        .DCM_RST_OUT(dcm_rst), .SYS_RSTN_OUT(sys_rstn), .READY_OUT(ready),
        .FAIL_OUT(fail), .RETRY_CNT_OUT(retry_cnt), .STATE_OUT(state)
    );

    always #5 clk = ~clk;

    // {state[1:0], dcm, sys_rstn, ready, fail, retry[3:0]}
    function automatic logic [9:0] mk(input int st, input bit d, input bit s,
                                      input bit r, input bit f, input int rt);
        return {st[1:0], d, s, r, f, rt[3:0]};
    endfunction

    function automatic logic [9:0] got_vec();
        return {state, dcm_rst, sys_rstn, ready, fail, retry_cnt};
    endfunction

    function automatic logic [9:0] model_vec();
        return mk(m_mode, (m_mode == 0) || (m_mode == 3), m_mode == 2,
                  m_mode == 2, m_mode == 3, m_retries);
    endfunction

    task automatic model_step(input logic r_n, input logic lk, input logic rs);
        if (!r_n || rs) begin
            m_mode = 0; m_elapsed = 0; m_run = 0; m_retries = 0;
        end else if (m_mode == 0) begin
            m_elapsed++;
            if (m_elapsed == RST_CYCLES) begin
                m_mode = 1; m_elapsed = 0; m_run = 0;
            end
        end else if (m_mode == 1) begin
            m_elapsed++;
            m_run = lk ? m_run + 1 : 0;
            if (m_run == LOCK_STABLE) begin
                m_mode = 2; m_retries = 0;
            end else if (m_elapsed == LOCK_TIMEOUT) begin
                if (m_retries < MAX_RETRY) begin
                    m_retries++; m_mode = 0; m_elapsed = 0;
                end else begin
                    m_mode = 3;
                end
            end
        end else if (m_mode == 2) begin
            if (!lk) begin
                m_mode = 0; m_elapsed = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] g;
        g = got_vec();
        n_cmp++;
        if (g !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %b required %b", name, cyc, g, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare 1 time unit after the edge.
    task automatic step(input logic r_n, input logic lk, input logic rs);
        rstn = r_n; locked = lk; restart = rs;
        @(posedge clk);
        model_step(r_n, lk, rs);
        #1;
        cyc++;
        check("model", model_vec());
    endtask

    typedef struct {
        logic       rstn;
        logic       lock;
        logic       restart;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[29];

    initial begin
        logic [9:0] E_RST, E_WAIT, E_RUN;
        int dcm_cnt;
        int prob, len;
        logic lk, rs, rn;

        E_RST  = mk(0, 1, 0, 0, 0, 0);
        E_WAIT = mk(1, 0, 0, 0, 0, 0);
        E_RUN  = mk(2, 0, 1, 1, 0, 0);

        // Bring-up, lock loss, glitch in RESET, and lock chatter.
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, E_RST};
        for (int i = 5; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, E_RST};
        for (int i = 8; i < 14; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, E_WAIT};
        tbl[14] = '{1'b1, 1'b1, 1'b0, E_WAIT};
        tbl[15] = '{1'b1, 1'b1, 1'b0, E_WAIT};
        tbl[16] = '{1'b1, 1'b1, 1'b0, E_RUN};
        tbl[17] = '{1'b1, 1'b0, 1'b0, E_RST};
        tbl[18] = '{1'b1, 1'b0, 1'b0, E_RST};
        tbl[19] = '{1'b1, 1'b1, 1'b0, E_RST};
        tbl[20] = '{1'b1, 1'b0, 1'b0, E_RST};
        tbl[21] = '{1'b1, 1'b1, 1'b0, E_WAIT};
        tbl[22] = '{1'b1, 1'b1, 1'b0, E_WAIT};
        tbl[23] = '{1'b1, 1'b1, 1'b0, E_WAIT};
        tbl[24] = '{1'b1, 1'b0, 1'b0, E_WAIT};
        tbl[25] = '{1'b1, 1'b1, 1'b0, E_WAIT};
        tbl[26] = '{1'b1, 1'b1, 1'b0, E_WAIT};
        tbl[27] = '{1'b1, 1'b1, 1'b0, E_RUN};
        tbl[28] = '{1'b1, 1'b1, 1'b0, E_RUN};

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].rstn, tbl[i].lock, tbl[i].restart);
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Timeout, retries, then FAIL.
        step(1'b1, 1'b0, 1'b1);
        check("restart_to_reset", E_RST);
        dcm_cnt = int'(dcm_rst);
        for (int k = 1; k <= 72; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (k <= 71) dcm_cnt += int'(dcm_rst);
            if (k == 23) check("attempt1_last_wait", mk(1, 0, 0, 0, 0, 0));
            if (k == 24) check("retry1", mk(0, 1, 0, 0, 0, 1));
            if (k == 48) check("retry2", mk(0, 1, 0, 0, 0, 2));
            if (k == 71) check("attempt3_last_wait", mk(1, 0, 0, 0, 0, 2));
            if (k == 72) check("enter_fail", mk(3, 1, 0, 0, 1, 2));
        end
        n_cmp++;
        if (dcm_cnt != 12) begin
            n_bad++;
            $display("FAIL dcm_pulse_cycles: got %0d required %0d", dcm_cnt, 12);
        end
        for (int k = 0; k < 100; k++) step(1'b1, 1'b1, 1'b0);
        check("fail_persists", mk(3, 1, 0, 0, 1, 2));

        // Restart from FAIL with lock present.
        step(1'b1, 1'b1, 1'b1);
        check("fail_restart", E_RST);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (k == 3) check("restart_rst_hold", E_RST);
            if (k == 4) check("restart_wait", E_WAIT);
            if (k == 7) check("restart_run", E_RUN);
        end

        // One-cycle lock loss in RUN.
        step(1'b1, 1'b0, 1'b0);
        check("lock_loss", E_RST);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (k == 7) check("relock_run", E_RUN);
        end

        // RESTART_IN on a cycle that meets the lock condition.
        step(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("restart_beats_lock", E_RST);

        // RSTN_IN low together with RESTART_IN from RUN.
        for (int k = 1; k <= 7; k++) step(1'b1, 1'b1, 1'b0);
        check("run_before_rstn", E_RUN);
        step(1'b0, 1'b1, 1'b1);
        check("rstn_with_restart", E_RST);

        // Lock reached exactly on the timeout cycle of the second attempt.
        for (int k = 1; k <= 48; k++) begin
            step(1'b1, (k >= 46) ? 1'b1 : 1'b0, 1'b0);
            if (k == 24) check("late_lock_retry1", mk(0, 1, 0, 0, 0, 1));
            if (k == 47) check("late_lock_wait", mk(1, 0, 0, 0, 0, 1));
            if (k == 48) check("lock_at_timeout", E_RUN);
        end

        // Randomized segments with varying lock probability.
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 3))
                0: prob = 0;
                1: prob = 50;
                2: prob = 90;
                default: prob = 100;
            endcase
            len = $urandom_range(5, 60);
            for (int k = 0; k < len; k++) begin
                lk = ($urandom_range(0, 99) < prob);
                rs = ($urandom_range(0, 199) == 0);
                rn = !($urandom_range(0, 299) == 0);
                step(rn, lk, rs);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
